rf_control_sequencer: RTL and testbench

- Multi-cycle control sequencer sitting directly upstream of the register file.
- Fetches a 16-bit instruction from byte-wide memory, holds it in an internal IR, and drives the register file's FunSel/RegSel/ScrSel/OutASel/OutBSel, the ALU function select and the RF input mux.
- Executes a small register-to-register instruction set, one instruction at a time.

---
 rtl/rf_ctrl_pkg.sv | 43 ++++
 rtl/rf_sel_decode.sv | 20 ++
 rtl/rf_control_sequencer.sv | 170 +++++++++++++++++
 tb/tb_rf_control_sequencer.sv | 383 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared types and encodings for the register-file control sequencer.
// Holds the state enum, opcode values, RF function codes, ALU codes and RF input mux codes.
package rf_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH_L = 3'd1,
    ST_FETCH_H = 3'd2,
    ST_EXEC0   = 3'd3,
    ST_EXEC1   = 3'd4,
    ST_HALT    = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_INC  = 4'h1;
  localparam logic [3:0] OP_DEC  = 4'h2;
  localparam logic [3:0] OP_MOV  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_AND  = 4'h5;
  localparam logic [3:0] OP_CLR  = 4'h6;
  localparam logic [3:0] OP_LDI  = 4'h7;
  localparam logic [3:0] OP_INCC = 4'h8;
  localparam logic [3:0] OP_DECC = 4'h9;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam logic [2:0] FS_DEC   = 3'b000;
  localparam logic [2:0] FS_INC   = 3'b001;
  localparam logic [2:0] FS_LOAD  = 3'b010;
  localparam logic [2:0] FS_CLEAR = 3'b011;

  localparam logic [4:0] ALU_PASS_A = 5'd1;
  localparam logic [4:0] ALU_ADD    = 5'd2;
  localparam logic [4:0] ALU_AND    = 5'd3;

  localparam logic [1:0] MUX_ALU = 2'd0;
  localparam logic [1:0] MUX_IMM = 2'd1;

  // Opcodes 0..9 and F are defined; A..E are reserved and flagged as illegal.
  function automatic logic is_legal_op(input logic [3:0] op);
    return (op <= OP_DECC) || (op == OP_HLT);
  endfunction

endpackage

// File: rtl/rf_sel_decode.sv
// rf_sel_decode: destination index (0..3 = R1..R4, 4..7 = S1..S4) to active-low
// register/scratch enables. With en low both enable groups stay all-ones.
module rf_sel_decode (
  input  logic [2:0] idx,
  input  logic       en,
  output logic [3:0] reg_sel,
  output logic [3:0] scr_sel
);

  // One-cold enable: bit3 is the first register of each group.
  always_comb begin
    reg_sel = 4'hF;
    scr_sel = 4'hF;
    if (en) begin
      if (!idx[2]) reg_sel[2'd3 - idx[1:0]] = 1'b0;
      else         scr_sel[2'd3 - idx[1:0]] = 1'b0;
    end
  end

endmodule

// File: rtl/rf_control_sequencer.sv
// rf_control_sequencer: fetches 16-bit instructions as two bytes, then drives the
// register file and ALU controls for one or two execute cycles.
// Optional macro SEQ_STEP_EN adds a Step input that gates every entry into FETCH_L.
//
// state    | meaning
// ---------+----------------------------------------------
// IDLE     | waiting for Run (and Step when enabled)
// FETCH_L  | read low byte at PC into IR[7:0], PC+1
// FETCH_H  | read high byte at PC into IR[15:8], PC+1
// EXEC0    | first execute cycle, only cycle for most ops
// EXEC1    | second cycle of INCC/DECC (INC/DEC on Rd)
// HALT     | absorbing; left only through Reset
module rf_control_sequencer
  import rf_ctrl_pkg::*;
#(
  parameter logic [15:0] FETCH_BASE = 16'h0000,
  parameter int          ALU_FS_W   = 5
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                Run,
`ifdef SEQ_STEP_EN
  input  logic                Step,
`endif
  input  logic [7:0]          MemOut,
  output logic [15:0]         Mem_Addr,
  output logic                Mem_Rd,
  output logic [2:0]          RF_FunSel,
  output logic [3:0]          RF_RegSel,
  output logic [3:0]          RF_ScrSel,
  output logic [2:0]          RF_OutASel,
  output logic [2:0]          RF_OutBSel,
  output logic [ALU_FS_W-1:0] ALU_FunSel,
  output logic [1:0]          MuxASel,
  output logic                Halted,
  output logic                IllegalOp
);

  state_t      state, state_nxt;
  logic [15:0] pc;
  logic [15:0] ir;
  logic        illegal;
  logic        wr_en;
  logic        go;

  logic [3:0]  op;
  logic [2:0]  rd, rs1, rs2;
  logic        unused_ir;

  assign op  = ir[15:12];
  assign rd  = ir[11:9];
  assign rs1 = ir[8:6];
  assign rs2 = ir[5:3];
  // The immediate itself reaches the register file through its own mux.
  assign unused_ir = ^ir[2:0];

`ifdef SEQ_STEP_EN
  assign go = Run & Step;
`else
  assign go = Run;
`endif

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // PC, instruction register and sticky illegal-opcode flag.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pc      <= FETCH_BASE;
      ir      <= 16'h0000;
      illegal <= 1'b0;
    end else begin
      case (state)
        ST_FETCH_L: begin
          ir[7:0] <= MemOut;
          pc      <= pc + 16'd1;
        end
        ST_FETCH_H: begin
          ir[15:8] <= MemOut;
          pc       <= pc + 16'd1;
        end
        ST_EXEC0: if (!is_legal_op(op)) illegal <= 1'b1;
        default: ;
      endcase
    end
  end

  // Next-state and control outputs; everything idles at the no-write value.
  always_comb begin
    state_nxt  = state;
    Mem_Rd     = 1'b0;
    RF_FunSel  = 3'b000;
    wr_en      = 1'b0;
    RF_OutASel = 3'd0;
    RF_OutBSel = 3'd0;
    ALU_FunSel = '0;
    MuxASel    = MUX_ALU;
    case (state)
      ST_IDLE: if (go) state_nxt = ST_FETCH_L;
      ST_FETCH_L: begin
        Mem_Rd    = 1'b1;
        state_nxt = ST_FETCH_H;
      end
      ST_FETCH_H: begin
        Mem_Rd    = 1'b1;
        state_nxt = ST_EXEC0;
      end
      ST_EXEC0: begin
        state_nxt = go ? ST_FETCH_L : ST_IDLE;
        case (op)
          OP_INC: begin
            RF_FunSel = FS_INC;
            wr_en     = 1'b1;
          end
          OP_DEC: begin
            RF_FunSel = FS_DEC;
            wr_en     = 1'b1;
          end
          OP_MOV, OP_INCC, OP_DECC: begin
            RF_OutASel = rs1;
            ALU_FunSel = ALU_FS_W'(ALU_PASS_A);
            RF_FunSel  = FS_LOAD;
            wr_en      = 1'b1;
            if (op != OP_MOV) state_nxt = ST_EXEC1;
          end
          OP_ADD, OP_AND: begin
            RF_OutASel = rs1;
            RF_OutBSel = rs2;
            ALU_FunSel = (op == OP_ADD) ? ALU_FS_W'(ALU_ADD) : ALU_FS_W'(ALU_AND);
            RF_FunSel  = FS_LOAD;
            wr_en      = 1'b1;
          end
          OP_CLR: begin
            RF_FunSel = FS_CLEAR;
            wr_en     = 1'b1;
          end
          OP_LDI: begin
            MuxASel   = MUX_IMM;
            RF_FunSel = FS_LOAD;
            wr_en     = 1'b1;
          end
          OP_HLT: state_nxt = ST_HALT;
          default: ;
        endcase
      end
      ST_EXEC1: begin
        RF_FunSel = (op == OP_DECC) ? FS_DEC : FS_INC;
        wr_en     = 1'b1;
        state_nxt = go ? ST_FETCH_L : ST_IDLE;
      end
      ST_HALT: state_nxt = ST_HALT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  rf_sel_decode u_sel_decode (
    .idx     (rd),
    .en      (wr_en),
    .reg_sel (RF_RegSel),
    .scr_sel (RF_ScrSel)
  );

  assign Mem_Addr  = pc;
  assign Halted    = (state == ST_HALT);
  assign IllegalOp = illegal;

endmodule

// File: tb/tb_rf_control_sequencer.sv
// tb_rf_control_sequencer: runs a short program through the sequencer with a
// byte-wide memory model; expected execute-cycle controls are queued at load time.
module tb_rf_control_sequencer;
  import rf_ctrl_pkg::*;

  localparam logic [15:0] BASE = 16'hFFFF;   // first fetch straddles the PC wrap
  localparam int NPROG = 14;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Run;
`ifdef SEQ_STEP_EN
  logic        Step;
`endif
  logic [7:0]  MemOut;
  logic [15:0] Mem_Addr;
  logic        Mem_Rd;
  logic [2:0]  RF_FunSel;
  logic [3:0]  RF_RegSel;
  logic [3:0]  RF_ScrSel;
  logic [2:0]  RF_OutASel;
  logic [2:0]  RF_OutBSel;
  logic [4:0]  ALU_FunSel;
  logic [1:0]  MuxASel;
  logic        Halted;
  logic        IllegalOp;

  logic [7:0]  mem [0:65535];
  logic [23:0] sbq [$];
  logic [15:0] prog [NPROG];
  logic [15:0] pc_model;
  int          errors = 0;
  int          checks = 0;

  // snapshots of the last EXEC0 / EXEC1 cycle, {fs,reg,scr,oa,ob,alu,mux}
  logic [23:0] ex0, ex1;

  always #5 Clock = ~Clock;
  assign MemOut = mem[Mem_Addr];

  rf_control_sequencer #(.FETCH_BASE(BASE), .ALU_FS_W(5)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Run        (Run),
`ifdef SEQ_STEP_EN
    .Step       (Step),
`endif
    .MemOut     (MemOut),
    .Mem_Addr   (Mem_Addr),
    .Mem_Rd     (Mem_Rd),
    .RF_FunSel  (RF_FunSel),
    .RF_RegSel  (RF_RegSel),
    .RF_ScrSel  (RF_ScrSel),
    .RF_OutASel (RF_OutASel),
    .RF_OutBSel (RF_OutBSel),
    .ALU_FunSel (ALU_FunSel),
    .MuxASel    (MuxASel),
    .Halted     (Halted),
    .IllegalOp  (IllegalOp)
  );

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // {reg_sel, scr_sel} for a destination index
  function automatic logic [7:0] sel_of(input logic [2:0] idx);
    logic [3:0] r, s;
    r = 4'hF;
    s = 4'hF;
    if (idx < 3'd4) r = ~(4'b1000 >> idx);
    else            s = ~(4'b1000 >> (idx - 3'd4));
    return {r, s};
  endfunction

  // expected controls for one execute cycle of an instruction
  function automatic logic [23:0] exp_cycle(input logic [15:0] ins, input bit second);
    logic [3:0] op;
    logic [2:0] fs, oa, ob;
    logic [4:0] alu;
    logic [1:0] mux;
    bit         we;
    op = ins[15:12];
    fs = 3'b000; oa = 3'd0; ob = 3'd0; alu = 5'd0; mux = MUX_ALU; we = 0;
    if (second) begin
      we = 1;
      fs = (op == 4'h9) ? FS_DEC : FS_INC;
    end else begin
      case (op)
        4'h1: begin fs = FS_INC; we = 1; end
        4'h2: begin fs = FS_DEC; we = 1; end
        4'h3, 4'h8, 4'h9: begin oa = ins[8:6]; alu = ALU_PASS_A; fs = FS_LOAD; we = 1; end
        4'h4: begin oa = ins[8:6]; ob = ins[5:3]; alu = ALU_ADD; fs = FS_LOAD; we = 1; end
        4'h5: begin oa = ins[8:6]; ob = ins[5:3]; alu = ALU_AND; fs = FS_LOAD; we = 1; end
        4'h6: begin fs = FS_CLEAR; we = 1; end
        4'h7: begin mux = MUX_IMM; fs = FS_LOAD; we = 1; end
        default: ;
      endcase
    end
    return {fs, (we ? sel_of(ins[11:9]) : 8'hFF), oa, ob, alu, mux};
  endfunction

  task automatic load_instr(input logic [15:0] addr, input logic [15:0] ins);
    logic [15:0] a1;
    a1 = addr + 16'd1;
    mem[addr] = ins[7:0];
    mem[a1]   = ins[15:8];
    sbq.push_back(exp_cycle(ins, 0));
    if (ins[15:12] == 4'h8 || ins[15:12] == 4'h9) sbq.push_back(exp_cycle(ins, 1));
  endtask

  // Entered while sampling FETCH_L; returns sampling the cycle after the last EXEC.
  task automatic run_instr(input logic [15:0] ins, input bit drop_run);
    logic [23:0] act, exp;
    bit          two;
    two = (ins[15:12] == 4'h8) || (ins[15:12] == 4'h9);
    checks++;
    if (Mem_Rd !== 1'b1 || Mem_Addr !== pc_model) begin
      errors++;
      $display("FAIL fetch_l ins=%h: rd=%b addr=%h, expected rd=1 addr=%h", ins, Mem_Rd, Mem_Addr, pc_model);
    end
    tick();
    checks++;
    if (Mem_Rd !== 1'b1 || Mem_Addr !== 16'(pc_model + 16'd1) || {RF_RegSel, RF_ScrSel} !== 8'hFF) begin
      errors++;
      $display("FAIL fetch_h ins=%h: rd=%b addr=%h sel=%h, expected rd=1 addr=%h sel=ff",
               ins, Mem_Rd, Mem_Addr, {RF_RegSel, RF_ScrSel}, 16'(pc_model + 16'd1));
    end
    if (drop_run) Run = 1'b0;
    tick();
    checks++;
    if (Mem_Rd !== 1'b0 || Mem_Addr !== 16'(pc_model + 16'd2) || Halted !== 1'b0) begin
      errors++;
      $display("FAIL exec0_ctrl ins=%h: rd=%b addr=%h halted=%b, expected rd=0 addr=%h halted=0",
               ins, Mem_Rd, Mem_Addr, Halted, 16'(pc_model + 16'd2));
    end
    act = {RF_FunSel, RF_RegSel, RF_ScrSel, RF_OutASel, RF_OutBSel, ALU_FunSel, MuxASel};
    ex0 = act;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL exec0_sb ins=%h: got %h, expected nothing queued", ins, act);
    end else begin
      exp = sbq.pop_front();
      if (act !== exp) begin
        errors++;
        $display("FAIL exec0_sb ins=%h: got %h, expected %h", ins, act, exp);
      end
    end
    if (two) begin
      tick();
      act = {RF_FunSel, RF_RegSel, RF_ScrSel, RF_OutASel, RF_OutBSel, ALU_FunSel, MuxASel};
      ex1 = act;
      checks++;
      if (sbq.size() == 0 || Mem_Rd !== 1'b0) begin
        errors++;
        $display("FAIL exec1_sb ins=%h: got %h rd=%b, expected queued entry rd=0", ins, act, Mem_Rd);
      end else begin
        exp = sbq.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL exec1_sb ins=%h: got %h, expected %h", ins, act, exp);
        end
      end
    end
    tick();
    pc_model = pc_model + 16'd2;
    checks++;
    if (ins[15:12] == 4'hF) begin
      if (Halted !== 1'b1 || Mem_Rd !== 1'b0) begin
        errors++;
        $display("FAIL halt_entry: halted=%b rd=%b, expected halted=1 rd=0", Halted, Mem_Rd);
      end
    end else if (Run) begin
      if (Mem_Rd !== 1'b1 || Mem_Addr !== pc_model || {RF_RegSel, RF_ScrSel} !== 8'hFF) begin
        errors++;
        $display("FAIL next_fetch ins=%h: rd=%b addr=%h sel=%h, expected rd=1 addr=%h sel=ff",
                 ins, Mem_Rd, Mem_Addr, {RF_RegSel, RF_ScrSel}, pc_model);
      end
    end else begin
      if (Mem_Rd !== 1'b0 || Halted !== 1'b0 || {RF_RegSel, RF_ScrSel} !== 8'hFF) begin
        errors++;
        $display("FAIL idle_entry ins=%h: rd=%b halted=%b sel=%h, expected rd=0 halted=0 sel=ff",
                 ins, Mem_Rd, Halted, {RF_RegSel, RF_ScrSel});
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (Mem_Addr !== BASE || RF_RegSel !== 4'hF || RF_ScrSel !== 4'hF || Mem_Rd !== 1'b0 ||
        Halted !== 1'b0 || IllegalOp !== 1'b0 || RF_FunSel !== 3'd0 || MuxASel !== 2'd0 ||
        RF_OutASel !== 3'd0 || RF_OutBSel !== 3'd0 || ALU_FunSel !== 5'd0) begin
      errors++;
      $display("FAIL reset_state: addr=%h sel=%h rd=%b halt=%b ill=%b fs=%h mux=%h oa=%h ob=%h alu=%h, expected addr=%h sel=ff rest 0",
               Mem_Addr, {RF_RegSel, RF_ScrSel}, Mem_Rd, Halted, IllegalOp, RF_FunSel, MuxASel,
               RF_OutASel, RF_OutBSel, ALU_FunSel, BASE);
    end
  endtask

  task automatic test_reset_mid_fetch();
    Run = 1'b1;
    @(negedge Clock);
    Reset = 1'b1;
    tick();
    checks++;
    if (Mem_Rd !== 1'b1 || Mem_Addr !== 16'hFFFF) begin
      errors++;
      $display("FAIL wrap_fetch_l: rd=%b addr=%h, expected rd=1 addr=ffff", Mem_Rd, Mem_Addr);
    end
    tick();
    checks++;
    if (Mem_Rd !== 1'b1 || Mem_Addr !== 16'h0000) begin
      errors++;
      $display("FAIL wrap_fetch_h: rd=%b addr=%h, expected rd=1 addr=0000", Mem_Rd, Mem_Addr);
    end
    #3 Reset = 1'b0;
    #1;
    checks++;
    if (Mem_Addr !== BASE || {RF_RegSel, RF_ScrSel} !== 8'hFF || Mem_Rd !== 1'b0 || dut.ir !== 16'h0000) begin
      errors++;
      $display("FAIL reset_mid_fetch: addr=%h sel=%h rd=%b ir=%h, expected addr=%h sel=ff rd=0 ir=0000",
               Mem_Addr, {RF_RegSel, RF_ScrSel}, Mem_Rd, dut.ir, BASE);
    end
    @(negedge Clock);
    Reset = 1'b1;
    pc_model = BASE;
    tick();
  endtask

  task automatic test_ldi_wrap();
    run_instr(prog[0], 0);
    checks++;
    if (ex0[23:21] !== FS_LOAD || ex0[20:17] !== 4'b1011 || ex0[16:13] !== 4'hF || ex0[1:0] !== MUX_IMM) begin
      errors++;
      $display("FAIL ldi_exec0: fs=%h reg=%b scr=%b mux=%h, expected fs=2 reg=1011 scr=1111 mux=1",
               ex0[23:21], ex0[20:17], ex0[16:13], ex0[1:0]);
    end
  endtask

  task automatic test_add();
    run_instr(prog[1], 0);
    checks++;
    if (ex0 !== {FS_LOAD, 4'b0111, 4'b1111, 3'd1, 3'd6, ALU_ADD, MUX_ALU}) begin
      errors++;
      $display("FAIL add_exec0: got %h, expected %h", ex0, {FS_LOAD, 4'b0111, 4'b1111, 3'd1, 3'd6, ALU_ADD, MUX_ALU});
    end
  endtask

  task automatic test_incc();
    run_instr(prog[2], 0);
    checks++;
    if (ex0[23:21] !== FS_LOAD || ex0[16:13] !== 4'b1110 || ex0[12:10] !== 3'd3 ||
        ex1[23:21] !== FS_INC || ex1[20:17] !== 4'hF || ex1[16:13] !== 4'b1110) begin
      errors++;
      $display("FAIL incc_cycles: ex0=%h ex1=%h, expected ex0 fs=2 scr=1110 oa=3, ex1 fs=1 reg=1111 scr=1110", ex0, ex1);
    end
  endtask

  task automatic test_ops_table();
    for (int i = 3; i <= 8; i++) run_instr(prog[i], 0);
  endtask

  task automatic test_run_stop();
    run_instr(prog[9], 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (Mem_Rd !== 1'b0 || Mem_Addr !== pc_model) begin
        errors++;
        $display("FAIL idle_hold: rd=%b addr=%h, expected rd=0 addr=%h", Mem_Rd, Mem_Addr, pc_model);
      end
    end
    Run = 1'b1;
    tick();
  endtask

  task automatic test_illegal();
    run_instr(prog[10], 0);
    checks++;
    if (IllegalOp !== 1'b0) begin
      errors++;
      $display("FAIL illegal_before: got %b, expected 0", IllegalOp);
    end
    run_instr(prog[11], 0);
    checks++;
    if (IllegalOp !== 1'b1 || ex0[20:13] !== 8'hFF) begin
      errors++;
      $display("FAIL illegal_flag: flag=%b sel=%h, expected flag=1 sel=ff", IllegalOp, ex0[20:13]);
    end
    run_instr(prog[12], 0);
    checks++;
    if (IllegalOp !== 1'b1) begin
      errors++;
      $display("FAIL illegal_sticky: got %b, expected 1", IllegalOp);
    end
  endtask

  task automatic test_halt();
    run_instr(prog[13], 0);
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (Halted !== 1'b1 || Mem_Rd !== 1'b0 || {RF_RegSel, RF_ScrSel} !== 8'hFF) begin
        errors++;
        $display("FAIL halt_hold: halted=%b rd=%b sel=%h, expected halted=1 rd=0 sel=ff",
                 Halted, Mem_Rd, {RF_RegSel, RF_ScrSel});
      end
    end
    #2 Reset = 1'b0;
    #1;
    checks++;
    if (Halted !== 1'b0 || IllegalOp !== 1'b0 || Mem_Addr !== BASE) begin
      errors++;
      $display("FAIL halt_reset: halted=%b ill=%b addr=%h, expected 0 0 %h", Halted, IllegalOp, Mem_Addr, BASE);
    end
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d entries left, expected 0", sbq.size());
    end
  endtask

`ifdef SEQ_STEP_EN
  task automatic test_step();
    Step = 1'b0;
    Run  = 1'b1;
    @(negedge Clock);
    Reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (Mem_Rd !== 1'b0) begin
        errors++;
        $display("FAIL step_gate: rd=%b, expected 0 while Step=0", Mem_Rd);
      end
    end
    Step = 1'b1;
    tick();
    checks++;
    if (Mem_Rd !== 1'b1 || Mem_Addr !== BASE) begin
      errors++;
      $display("FAIL step_release: rd=%b addr=%h, expected rd=1 addr=%h", Mem_Rd, Mem_Addr, BASE);
    end
  endtask
`endif

  initial begin
    Reset = 1'b0;
    Run   = 1'b0;
`ifdef SEQ_STEP_EN
    Step  = 1'b1;
`endif
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    prog = '{16'h7255, 16'h4070, 16'h8EC0, 16'h1600, 16'h2800, 16'h3240, 16'h5258,
             16'h6C00, 16'h9000, 16'h6400, 16'h0000, 16'hB000, 16'h4070, 16'hF000};
    for (int i = 0; i < NPROG; i++) load_instr(16'(BASE + 16'(2 * i)), prog[i]);
    pc_model = BASE;
    #12;
    test_reset();
    test_reset_mid_fetch();
    test_ldi_wrap();
    test_add();
    test_incc();
    test_ops_table();
    test_run_stop();
    test_illegal();
    test_halt();
`ifdef SEQ_STEP_EN
    test_step();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
